nibble_serializer_ctrl: RTL

Control stage directly upstream of the 4-bit load/shift-left register. It accepts 4-bit nibbles from a producer over a valid/ready handshake and drives the register's command (`b0`) and parallel-load data (`x3_x0`). It reads the register contents back and presents them to a downstream consumer as an MSB-first serial stream with valid/ready and a frame-end marker. The register has no hold function, so stalls are implemented by reloading its current contents.

---
 rtl/serializer_pkg.sv | 14 +
 rtl/frame_counter.sv | 25 ++
 rtl/nibble_serializer_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types and constants for the nibble serializer controller.
package serializer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic CMD_LOAD  = 1'b0;
    localparam logic CMD_SHIFT = 1'b1;

endpackage

// File: rtl/frame_counter.sv
// Wrapping modulo-N counter with enable, synchronous clear and terminal count.
module frame_counter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(N - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nibble_serializer_ctrl.sv
// Drives a 4-bit load/shift-left register to stream nibbles MSB-first.
module nibble_serializer_ctrl
    import serializer_pkg::*;
#(
    parameter int FRAME_NIBBLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [NIBBLE_W-1:0] in_data,
    output logic                in_ready,
    input  logic [NIBBLE_W-1:0] reg_q,
    output logic                b0,
    output logic [NIBBLE_W-1:0] x3_x0,
    output logic                ser_out,
    output logic                ser_valid,
    output logic                ser_last,
    input  logic                ser_ready
);

    state_t state;
    logic   send;
    logic   bit_tc;
    logic   nib_tc;
    logic   done;
    logic   accept;
    logic   shift;

    assign send      = (state == ST_SEND);
    assign done      = send && ser_ready && bit_tc;
    assign in_ready  = !reset && (!send || done);
    assign accept    = in_valid && in_ready;
    assign shift     = !reset && send && ser_ready && !bit_tc;
    assign ser_valid = !reset && send;
    assign ser_last  = ser_valid && bit_tc && nib_tc;
    assign ser_out   = reg_q[NIBBLE_W-1];

    // The register cannot hold, so every non-load, non-shift cycle reloads it.
    always_comb begin
        b0    = CMD_LOAD;
        x3_x0 = reg_q;
        if (accept) begin
            x3_x0 = in_data;
        end else if (shift) begin
            b0 = CMD_SHIFT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (accept) begin
            state <= ST_SEND;
        end else if (done) begin
            state <= ST_IDLE;
        end
    end

    frame_counter #(.N(4)) u_bit_cnt (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .en    (shift),
        .tc    (bit_tc)
    );

    // Only completed nibbles advance the frame, so idle gaps do not break it.
    frame_counter #(.N(FRAME_NIBBLES)) u_nib_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (done && !reset),
        .tc    (nib_tc)
    );

endmodule
